// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter loading one of four registers over a shared bus: IDLE->SETUP->LOAD->ACK.
// Latency: 4 cycles per transfer; requests are sampled only in IDLE and wait while busy.
module reg_load_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] req_data,
    input  logic [7:0]         req_dst,
    output logic [3:0]         ack,
    output logic [WIDTH-1:0]   bus_d,
    output logic [3:0]         ei,
    output logic               busy,
    output logic [1:0]         last_grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        LOAD  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t           state_q;
    logic [3:0]       ack_q;
    logic [3:0]       ei_q;
    logic [WIDTH-1:0] bus_q;
    logic [1:0]       dst_q;
    logic [1:0]       lg_q;
    logic             busy_q;
    logic [1:0]       winner_d;

    // Search starts one past the previous winner and wraps.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        winner_d = lg_q;
        found    = 1'b0;
        idx      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = lg_q + 2'(k);
            if (!found && req[idx]) begin
                winner_d = idx;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ack_q   <= 4'd0;
            ei_q    <= 4'd0;
            bus_q   <= '0;
            dst_q   <= 2'd0;
            lg_q    <= 2'd3;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q <= SETUP;
                        busy_q  <= 1'b1;
                        lg_q    <= winner_d;
                        bus_q   <= req_data[winner_d*WIDTH +: WIDTH];
                        dst_q   <= req_dst[winner_d*2 +: 2];
                    end
                end
                SETUP: begin
                    state_q <= LOAD;
                    ei_q    <= 4'b0001 << dst_q;
                end
                LOAD: begin
                    state_q <= ACK;
                    ei_q    <= 4'd0;
                    ack_q   <= 4'b0001 << lg_q;
                end
                ACK: begin
                    state_q <= IDLE;
                    ack_q   <= 4'd0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 4'd0;
                    ei_q    <= 4'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ack        = ack_q;
    assign ei         = ei_q;
    assign bus_d      = bus_q;
    assign busy       = busy_q;
    assign last_grant = lg_q;

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Bench for reg_load_arbiter: directed scenarios followed by randomized transfers against a transaction model.
module tb_reg_load_arbiter;
    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [3:0]     req;
    logic [4*W-1:0] req_data;
    logic [7:0]     req_dst;
    logic [3:0]     ack;
    logic [W-1:0]   bus_d;
    logic [3:0]     ei;
    logic           busy;
    logic [1:0]     last_grant;

    int             n_chk;
    int             n_fail;
    int             m_lg;
    logic [W-1:0]   exp_reg [4];
    logic [W-1:0]   tb_reg  [4];

    reg_load_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_data   (req_data),
        .req_dst    (req_dst),
        .ack        (ack),
        .bus_d      (bus_d),
        .ei         (ei),
        .busy       (busy),
        .last_grant (last_grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream register file loaded by the enables.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (ei[k]) tb_reg[k] <= bus_d;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'hF;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("rst_busy", busy, 0);
        chk("rst_ei", ei, 0);
        chk("rst_ack", ack, 0);
        chk("rst_bus", bus_d, 0);
        chk("rst_last_grant", last_grant, 3);
        rst_n = 1'b1;
        #1;
        chk("rst_release_busy", busy, 0);
        m_lg = 3;
    endtask

    // One full transfer; DUT is in IDLE and req != 0 on entry.
    task automatic xfer(input bit scr, input logic [3:0] set_s, input logic [3:0] clr_s,
                        input logic [3:0] set_l);
        int         w;
        logic [W-1:0] d;
        logic [1:0] t;
        w = -1;
        for (int k = 1; k <= 4; k++)
            if (w < 0 && req[(m_lg + k) % 4]) w = (m_lg + k) % 4;
        if (w < 0) begin
            chk("xfer_no_request", req, 4'hF);
            return;
        end
        d = req_data[w*W +: W];
        t = req_dst[w*2 +: 2];

        @(posedge clk); #1;
        chk("setup_busy", busy, 1);
        chk("setup_bus", bus_d, d);
        chk("setup_ei", ei, 0);
        chk("setup_ack", ack, 0);
        chk("grant", last_grant, w);
        req = (req | set_s) & ~clr_s;
        if (scr) begin
            req = 4'($urandom); req_data = $urandom; req_dst = 8'($urandom);
        end

        @(posedge clk); #1;
        chk("load_ei", ei, 32'd1 << t);
        chk("load_bus", bus_d, d);
        chk("load_ack", ack, 0);
        req = req | set_l;
        if (scr) begin
            req_data = $urandom; req_dst = 8'($urandom);
        end

        @(posedge clk); #1;
        chk("ack", ack, 32'd1 << w);
        chk("ack_ei", ei, 0);
        chk("ack_busy", busy, 1);
        req[w] = 1'b0;

        @(posedge clk); #1;
        chk("idle_busy", busy, 0);
        chk("idle_ack", ack, 0);
        chk("idle_ei", ei, 0);
        chk("hold_bus", bus_d, d);
        exp_reg[t] = d;
        for (int k = 0; k < 4; k++) chk("reg", tb_reg[k], exp_reg[k]);
        m_lg = w;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; m_lg = 3;
        for (int k = 0; k < 4; k++) begin
            exp_reg[k] = '0;
            tb_reg[k]  = '0;
        end
        req_data = '0; req_dst = '0;
        do_reset();

        // Single request from requester 1 to register 2
        req = 4'b0010; req_data = 32'h0000_A500; req_dst = 8'b00_00_10_00;
        xfer(0, 0, 0, 0);

        // Round-robin across all four, each dropping on its ack
        do_reset();
        req = 4'b1111; req_data = 32'h1312_1110; req_dst = 8'hE4;
        repeat (4) xfer(0, 0, 0, 0);

        // Wrap: last grant 2, requests 0 and 2 pending
        req = 4'b0100;
        xfer(0, 0, 0, 0);
        req = 4'b0101;
        xfer(0, 0, 0, 0);
        xfer(0, 0, 0, 0);

        // Requester 0 drops in SETUP, requester 3 arrives in LOAD
        req = 4'b0001;
        xfer(0, 4'b0000, 4'b0001, 4'b1000);
        chk("late_req_pending", req, 4'b1000);
        xfer(0, 0, 0, 0);

        // Two requesters colliding on register 0
        do_reset();
        req = 4'b0110; req_data = 32'h0044_3300; req_dst = 8'h00;
        xfer(0, 0, 0, 0);
        chk("collide_first", tb_reg[0], 8'h33);
        xfer(0, 0, 0, 0);
        chk("collide_second", tb_reg[0], 8'h44);

        // Reset during LOAD aborts the transfer
        req = 4'b1000; req_data = 32'hEE00_0000; req_dst = 8'b01_00_00_00;
        @(posedge clk); #1;
        chk("abort_setup_bus", bus_d, 8'hEE);
        @(posedge clk); #1;
        chk("abort_load_ei", ei, 4'b0010);
        rst_n = 1'b0;
        #1;
        chk("abort_ei", ei, 0);
        chk("abort_bus", bus_d, 0);
        chk("abort_busy", busy, 0);
        chk("abort_last_grant", last_grant, 3);
        req = 4'b0000;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_no_ack", ack, 0);
            chk("abort_no_ei", ei, 0);
            chk("abort_idle", busy, 0);
        end
        chk("abort_reg_kept", tb_reg[1], exp_reg[1]);
        m_lg = 3;

        // Randomized transfers with input churn while busy
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                req = 4'b0000;
                @(posedge clk); #1;
                chk("rand_idle_busy", busy, 0);
                chk("rand_idle_ei", ei, 0);
            end
            req      = 4'($urandom_range(1, 15));
            req_data = $urandom;
            req_dst  = 8'($urandom);
            xfer(1, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_load_arbiter.md
REG_LOAD_ARBITER -- requirements
Module: reg_load_arbiter

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, data width of the shared register bus.
REQ-002 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk  input  1  sole clock; all state updates on posedge.
- rst_n  input  1  reset; asynchronous, active-low.
- req  input  4  per-requester load request, one bit per requester 0..3.
- req_data  input  4*WIDTH  requester i's load value, in bits [i*WIDTH +: WIDTH].
- req_dst  input  8  requester i's target register index (0..3), in bits [i*2 +: 2].
- ack  output  4  one-hot completion pulse to the granted requester.
- bus_d  output  WIDTH  shared data bus to the D inputs of registers 0..3.
- ei  output  4  one-hot load enable to registers 0..3.
- busy  output  1  high whenever state is not IDLE.
- last_grant  output  2  index of the most recently granted requester.

Function
REQ-003 The FSM SHALL have four states, IDLE, SETUP, LOAD and ACK, with these transitions:
- IDLE->SETUP when req != 0.
- SETUP->LOAD, LOAD->ACK and ACK->IDLE unconditionally.
REQ-004 The block SHALL select the winner on the IDLE->SETUP edge by round-robin: priority starts at (last_grant+1) mod 4 and ascends with wrap.
REQ-005 On the IDLE->SETUP edge the block SHALL update last_grant to the winner and latch the winner's req_data into bus_d and req_dst into an internal dst register.
REQ-006 bus_d SHALL hold the latched value through SETUP, LOAD and ACK, and until the next grant.
REQ-007 ei[dst] SHALL be 1 only during LOAD, for exactly one cycle; all ei bits SHALL be 0 in every other state.
REQ-008 ei SHALL be driven directly from flops that change only on posedge clk, so it is glitch-free for downstream clock gating.
REQ-009 Because SETUP precedes LOAD, bus_d SHALL be stable for at least one full cycle before any ei bit rises.
REQ-010 ack[winner] SHALL be 1 only during ACK, for exactly one cycle; all ack bits SHALL be 0 in every other state.
REQ-011 A transfer SHALL take 4 cycles from the first IDLE cycle with req != 0 to the return to IDLE; back-to-back grants SHALL occur every 4 cycles.
REQ-012 req, req_data and req_dst SHALL be sampled only in IDLE; changes during SETUP, LOAD or ACK SHALL have no effect, and a granted transfer SHALL always complete even if its req drops.
REQ-013 The requester SHALL deassert req[i] on the edge where it samples ack[i]=1; if req[i] is still high in the following IDLE cycle, the block SHALL treat it as a new request.
REQ-014 Requests arriving while busy=1 SHALL wait and be arbitrated in the next IDLE cycle.
REQ-015 Multiple requesters targeting the same register SHALL be served sequentially; the last-served value remains in that register.
REQ-016 Exactly one register SHALL be loaded per transfer; ei SHALL never have more than one bit set.

Reset
REQ-017 While rst_n=0 the block SHALL immediately, without waiting for a clock edge, force:
- state IDLE, ei=0, ack=0, busy=0
- bus_d=0, dst=0, last_grant=3, so requester 0 has top priority after reset.
REQ-018 Reset asserted mid-transfer SHALL abort the transfer: no ei or ack pulse SHALL occur for it after rst_n rises.
REQ-019 The block SHALL leave IDLE no earlier than the first posedge after rst_n rises.

Verification
REQ-020 Single request: after reset, req=4'b0010, req_data[1]=8'hA5, req_dst[1]=2 -> bus_d=A5 from cycle 1, ei=4'b0100 in cycle 2, ack=4'b0010 in cycle 3, register 2 holds A5, last_grant=1.
REQ-021 Round-robin: req=4'b1111 held with data 8'h10,8'h11,8'h12,8'h13 for requesters 0..3, dst=i, each requester dropping req on its ack -> grants in order 0,1,2,3 at 4-cycle spacing, registers 0..3 hold 10..13.
REQ-022 Wrap priority: last_grant=2, req=4'b0101 -> requester 0 is granted first, then requester 2.
REQ-023 Late and dropped requests: req[3] rises during LOAD of requester 0 -> requester 3 is granted on the first IDLE cycle. req[0] dropping during SETUP -> its ei and ack pulses still occur.
REQ-024 Reset mid-transfer: rst_n=0 during LOAD -> ei=0 and bus_d=0 immediately, no ack pulse, target register unchanged unless its load edge had already occurred.
REQ-025 Same-target collision: requesters 1 and 2 both with dst=0, data 8'h33 and 8'h44, req=4'b0110 from reset -> register 0 holds 33 after the first transfer and 44 after the second.
